// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter between the ALU and load unit in front of the register file,
// with a per-register busy scoreboard driven by decode reservations.
module regfile_wb_arbiter #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rsv_valid,
  input  logic [4:0]           rsv_addr,
  input  logic                 req0_valid,
  input  logic [4:0]           req0_addr,
  input  logic [WORD_SIZE-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [4:0]           req1_addr,
  input  logic [WORD_SIZE-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 rf_write_enable,
  output logic [4:0]           rf_write_addr,
  output logic [WORD_SIZE-1:0] rf_write_data,
  output logic [31:0]          busy
);

  logic                 ptr_q, ptr_d;
  logic                 we_q, we_d;
  logic [4:0]           waddr_q, waddr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [31:0]          busy_q, busy_d;

  logic                 grant1;
  logic                 xfer;
  logic [4:0]           xfer_addr;
  logic [WORD_SIZE-1:0] xfer_data;

  // ptr_q high means requester 1 wins a tie; it flips only on an actual transfer.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || ptr_q);
    req0_ready = reset_n && req0_valid && !grant1;
    req1_ready = reset_n && grant1;
    xfer       = req0_ready || req1_ready;
    xfer_addr  = grant1 ? req1_addr : req0_addr;
    xfer_data  = grant1 ? req1_data : req0_data;

    ptr_d   = xfer ? !grant1 : ptr_q;
    we_d    = xfer && (xfer_addr != 5'd0);
    waddr_d = we_d ? xfer_addr : waddr_q;
    wdata_d = we_d ? xfer_data : wdata_q;

    // Clear on commit first so a same-edge reservation of that register wins.
    busy_d = busy_q;
    if (xfer) busy_d[xfer_addr] = 1'b0;
    if (rsv_valid) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = waddr_q;
  assign rf_write_data   = wdata_q;
  assign busy            = busy_q;

endmodule
